serial_parity_checker: RTL and testbench
========================================

Name: serial_parity_checker

Overview:
Receiver-side counterpart of the 3-bit odd-parity generator. Deserialises a frame of DATA_W data bits followed by one parity bit, LSB first. Checks odd parity: data ones plus the parity bit must be odd. Presents the recovered word with an error flag through a one-cycle valid pulse to downstream lab logic.

Parameters:
DATA_W, 3, number of data bits per frame (legal 1..16)
ODD, 1, 1 = odd parity (matches the generator), 0 = even parity

Ports:
clk  input  1  system clock, rising edge
nrst  input  1  asynchronous active-low reset
start  input  1  frame start strobe; sampled only in IDLE
bit_valid  input  1  serial_in holds a valid bit this cycle
serial_in  input  1  serial data/parity bit
abort  input  1  synchronous frame cancel
busy  output  1  high while a frame is in progress (states DATA, PARITY)
data_out  output  DATA_W  last received data word
parity_err  output  1  parity result of last frame; 1 = mismatch
out_valid  output  1  one-cycle pulse: data_out and parity_err updated
err_cnt  output  8  saturating parity-error count (see Optional Feature)

Behaviour:
- Reset (nrst=0, async): state=IDLE, shift register=0, bit counter=0, data_out=0, parity_err=0, out_valid=0, busy=0, err_cnt=0.
- FSM states: IDLE, DATA, PARITY, DONE.
- IDLE: start=1 -> DATA, clear the shift register, bit counter and running XOR. bit_valid in IDLE is ignored.
- DATA: each cycle with bit_valid=1:
  - shift serial_in into position [cnt] (LSB first);
  - running XOR ^= serial_in;
  - cnt++.
  - When the DATA_W-th bit is sampled -> PARITY. Cycles with bit_valid=0 hold all state; gaps are unlimited.
- PARITY: on bit_valid=1, compute total = xor ^ serial_in.
  - Error when total != ODD, i.e. for ODD=1, error when total=0.
  - Register data_out and parity_err -> DONE.
- DONE: out_valid=1 for exactly this cycle -> IDLE. Latency: out_valid is high in the cycle after the parity bit is sampled.
- data_out and parity_err hold their values until the next completed frame.
- busy = (state==DATA || state==PARITY), combinational from state.
- start while busy or in DONE: ignored. A new frame may begin in the cycle after DONE.
- abort=1 in DATA or PARITY:
  - -> IDLE next cycle; partial data is discarded;
  - data_out, parity_err and err_cnt are unchanged; no out_valid.
  - abort has priority over bit_valid in the same cycle. abort in IDLE or DONE has no effect.
- Reset mid-frame: immediate return to the reset state; no out_valid is generated.

Optional Feature:
Macro PARITY_ERR_CNT_EN.
- Defined: err_cnt is an 8-bit counter, incremented in the cycle DONE is entered with parity_err=1. It saturates at 255 and is cleared only by nrst.
- Undefined: the counter logic is omitted and err_cnt is tied to 8'd0. The port is kept so the interface is identical.

Test Plan:
1. Parity bit accepted: DATA_W=3, ODD=1, data 3'b101 (serial 1,0,1), parity 1 -> out_valid pulse one cycle after the parity bit, data_out=3'b101, parity_err=0.
2. Parity error detected: data 3'b000, parity 0 -> parity_err=1; err_cnt 0->1 with the macro, stays 0 without it.
3. Gapped input: data 3'b111 with 2 idle bit_valid=0 cycles between each bit, parity 0 -> data_out=3'b111, parity_err=0; busy high throughout the frame.
4. Start while busy: start pulsed during DATA -> ignored, frame completes normally. Then abort during PARITY -> IDLE, no out_valid, data_out keeps the previous value.
5. Reset mid-frame: nrst low after 2 data bits -> all outputs 0 immediately. The next full frame, 3'b011 with parity 1, gives parity_err=0 and data_out=3'b011.
6. Saturation (macro defined): 260 error frames -> err_cnt=255 and holds.

Source files
------------

// File: rtl/serial_parity_checker_if.sv
// serial_parity_checker_if: frame control, serial bit stream and
// recovered-word result bundle for serial_parity_checker.
interface serial_parity_checker_if #(
  parameter int DATA_W = 3
);
  logic              start;
  logic              bit_valid;
  logic              serial_in;
  logic              abort;
  logic              busy;
  logic [DATA_W-1:0] data_out;
  logic              parity_err;
  logic              out_valid;
  logic [7:0]        err_cnt;

  modport master (
    output start,
    output bit_valid,
    output serial_in,
    output abort,
    input  busy,
    input  data_out,
    input  parity_err,
    input  out_valid,
    input  err_cnt
  );

  modport slave (
    input  start,
    input  bit_valid,
    input  serial_in,
    input  abort,
    output busy,
    output data_out,
    output parity_err,
    output out_valid,
    output err_cnt
  );
endinterface

// File: rtl/serial_parity_checker.sv
// serial_parity_checker: LSB-first frame deserialiser with parity check.
// Define PARITY_ERR_CNT_EN to build the saturating parity-error counter.
module serial_parity_checker #(
  parameter int DATA_W = 3,
  parameter int ODD    = 1
) (
  input  logic                    clk,
  input  logic                    nrst,
  serial_parity_checker_if.slave  bus
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);
  localparam logic ODD_B = (ODD != 0);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt;
  logic              xor_q;
  logic [DATA_W-1:0] data_q;
  logic              err_q;
  logic              busy;
  logic              out_valid;
  logic              take_bit;
  logic              err_now;

  assign take_bit = bus.bit_valid && !bus.abort;
  assign err_now  = (xor_q ^ bus.serial_in) != ODD_B;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.start) state_nxt = DATA;
      end
      DATA: begin
        if (bus.abort)
          state_nxt = IDLE;
        else if (bus.bit_valid && cnt == LAST)
          state_nxt = PARITY;
      end
      PARITY: begin
        if (bus.abort)
          state_nxt = IDLE;
        else if (bus.bit_valid)
          state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    out_valid = 1'b0;
    unique case (1'b1)
      state == DATA,
      state == PARITY: busy      = 1'b1;
      state == DONE:   out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      shreg  <= '0;
      cnt    <= '0;
      xor_q  <= 1'b0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            shreg <= '0;
            cnt   <= '0;
            xor_q <= 1'b0;
          end
        end
        DATA: begin
          if (take_bit) begin
            shreg[cnt] <= bus.serial_in;
            xor_q      <= xor_q ^ bus.serial_in;
            cnt        <= cnt + 1'b1;
          end
        end
        PARITY: begin
          if (take_bit) begin
            data_q <= shreg;
            err_q  <= err_now;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PARITY_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  // bumps on the same edge that enters DONE with a mismatch
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      err_cnt_q <= 8'd0;
    end else if (state == PARITY && take_bit && err_now
                 && err_cnt_q != 8'hff) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.err_cnt = err_cnt_q;
`else
  assign bus.err_cnt = 8'd0;
`endif

  assign bus.busy       = busy;
  assign bus.out_valid  = out_valid;
  assign bus.data_out   = data_q;
  assign bus.parity_err = err_q;

endmodule

// File: tb/tb_serial_parity_checker.sv
// tb_serial_parity_checker: directed frames against hand-computed
// results for DATA_W=3, odd parity.
module tb_serial_parity_checker;

  logic clk;
  logic nrst;
  int   n_chk;
  int   n_fail;

  logic [2:0] exp_data;
  logic       exp_err;
  logic [7:0] exp_cnt;

  serial_parity_checker_if #(.DATA_W(3)) bus ();

  serial_parity_checker #(
    .DATA_W(3),
    .ODD   (1)
  ) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_ov"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_data"}, 32'(bus.data_out), 32'(exp_data));
    chk({tag, "_err"}, 32'(bus.parity_err), 32'(exp_err));
    chk({tag, "_cnt"}, 32'(bus.err_cnt), 32'(exp_cnt));
  endtask

  task automatic send_bits(input logic [2:0] d, input int gap,
                           input bit poke_start);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      bus.bit_valid = 1'b1;
      bus.serial_in = d[i];
      @(negedge clk);
      bus.bit_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        bus.start = poke_start;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_gap", 32'(bus.busy), 32'd1);
      end
    end
  endtask

  task automatic send_frame(input logic [2:0] d, input logic p,
                            input int gap, input bit poke_start);
    send_bits(d, gap, poke_start);
    chk("busy_parity", 32'(bus.busy), 32'd1);
    chk("ov_early", 32'(bus.out_valid), 32'd0);
    bus.bit_valid = 1'b1;
    bus.serial_in = p;
    @(negedge clk);
    bus.bit_valid = 1'b0;
    exp_data = d;
    exp_err  = ~(^{d, p});
`ifdef PARITY_ERR_CNT_EN
    if (exp_err && exp_cnt != 8'hff) exp_cnt = exp_cnt + 8'd1;
`endif
    chk("ov_pulse", 32'(bus.out_valid), 32'd1);
    chk("busy_done", 32'(bus.busy), 32'd0);
    chk("data_out", 32'(bus.data_out), 32'(exp_data));
    chk("parity_err", 32'(bus.parity_err), 32'(exp_err));
    chk("err_cnt", 32'(bus.err_cnt), 32'(exp_cnt));
    @(negedge clk);
    chk("ov_drop", 32'(bus.out_valid), 32'd0);
    chk("busy_idle", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    n_chk         = 0;
    n_fail        = 0;
    exp_data      = 3'b000;
    exp_err       = 1'b0;
    exp_cnt       = 8'd0;
    nrst          = 1'b0;
    bus.start     = 1'b0;
    bus.bit_valid = 1'b0;
    bus.serial_in = 1'b0;
    bus.abort     = 1'b0;

    #12;
    chk_idle_outputs("reset");
    @(negedge clk);
    nrst = 1'b1;

    // bit_valid while idle must not start or disturb anything
    bus.bit_valid = 1'b1;
    bus.serial_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.bit_valid = 1'b0;
    chk_idle_outputs("idle_bits");

    send_frame(3'b101, 1'b1, 0, 1'b0);
    send_frame(3'b000, 1'b0, 0, 1'b0);
    send_frame(3'b111, 1'b0, 2, 1'b0);
    send_frame(3'b110, 1'b1, 1, 1'b1);

    // abort during the parity slot wins over bit_valid
    send_bits(3'b011, 0, 1'b0);
    bus.abort     = 1'b1;
    bus.bit_valid = 1'b1;
    bus.serial_in = 1'b1;
    @(negedge clk);
    bus.abort     = 1'b0;
    bus.bit_valid = 1'b0;
    chk_idle_outputs("abort_par");
    @(negedge clk);
    chk_idle_outputs("abort_par2");

    // abort mid data
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.bit_valid = 1'b1;
    bus.serial_in = 1'b1;
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort     = 1'b0;
    bus.bit_valid = 1'b0;
    chk_idle_outputs("abort_data");

    send_frame(3'b010, 1'b1, 0, 1'b0);
    send_frame(3'b100, 1'b1, 0, 1'b0);

    // reset after two data bits
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.bit_valid = 1'b1;
    bus.serial_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.bit_valid = 1'b0;
    #1;
    nrst = 1'b0;
    #1;
    exp_data = 3'b000;
    exp_err  = 1'b0;
    exp_cnt  = 8'd0;
    chk_idle_outputs("mid_reset");
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    chk_idle_outputs("post_reset");
    send_frame(3'b011, 1'b1, 0, 1'b0);

    for (int k = 0; k < 260; k++) send_frame(3'b000, 1'b0, 0, 1'b0);
`ifdef PARITY_ERR_CNT_EN
    chk("err_cnt_sat", 32'(bus.err_cnt), 32'd255);
`else
    chk("err_cnt_off", 32'(bus.err_cnt), 32'd0);
`endif
    send_frame(3'b001, 1'b0, 0, 1'b0);
    send_frame(3'b001, 1'b1, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
